// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM states,
// ALU/mux select codes and trap causes.
package rv32i_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_LUI    = 4'd4,
    S_AUIPC  = 4'd5,
    S_WB_ALU = 4'd6,
    S_ADDR   = 4'd7,
    S_MEM_RD = 4'd8,
    S_WB_MEM = 4'd9,
    S_MEM_WR = 4'd10,
    S_BRANCH = 4'd11,
    S_JAL    = 4'd12,
    S_JALR   = 4'd13,
    S_TRAP   = 4'd14
  } state_t;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_ITYPE  = 2'b10;
  localparam logic [1:0] ALU_RTYPE  = 2'b11;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;
  localparam logic [1:0] SRC_A_ZERO   = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] WB_ALU_OUT = 2'b00;
  localparam logic [1:0] WB_MEM     = 2'b01;
  localparam logic [1:0] WB_PC      = 2'b10;

  localparam logic PC_SRC_ALU     = 1'b0;
  localparam logic PC_SRC_ALU_OUT = 1'b1;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts consecutive unanswered memory-request cycles within one state and
// flags the cycle in which the request has waited MEM_TIMEOUT cycles.
module mem_timeout_counter #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ready,
  input  logic state_change,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (state_change || !active) begin
      count <= 8'd0;
    end else if (!ready && count != 8'hff) begin
      count <= count + 8'd1;
    end
  end

  // A response arriving in the final allowed cycle still completes the access.
  assign expired = active && !ready && (count == LIMIT);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main sequencer of the multi-cycle RV32I core: steps fetch/decode/execute/
// memory/writeback and halts on illegal opcodes or memory timeouts.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_src,
  output logic       old_pc_write,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       trap,
  output logic [1:0] trap_cause
);

  import rv32i_ctrl_pkg::*;

  // Handshake: mem_req stays high until the cycle mem_ready is seen; that
  // cycle completes the access and the FSM moves on at the next edge.

  state_t     state;
  state_t     state_next;
  logic [1:0] trap_cause_q;
  logic [1:0] cause_next;
  logic       expired;
  logic       state_change;

  mem_timeout_counter #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timeout (
    .clk          (clk),
    .rst          (rst),
    .active       (mem_req),
    .ready        (mem_ready),
    .state_change (state_change),
    .expired      (expired)
  );

  always_comb begin
    state_next = state;
    cause_next = CAUSE_NONE;
    case (state)
      S_FETCH: begin
        if (mem_ready) begin
          state_next = S_DECODE;
        end else if (expired) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:           state_next = S_EXEC_R;
          OP_ITYPE:           state_next = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_next = S_ADDR;
          OP_BRANCH:          state_next = S_BRANCH;
          OP_JAL:             state_next = S_JAL;
          OP_JALR:            state_next = S_JALR;
          OP_LUI:             state_next = S_LUI;
          OP_AUIPC:           state_next = S_AUIPC;
          default: begin
            state_next = S_TRAP;
            cause_next = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: state_next = S_WB_ALU;
      S_ADDR:   state_next = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready) begin
          state_next = S_WB_MEM;
        end else if (expired) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_next = S_FETCH;
        end else if (expired) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JALR: state_next = S_FETCH;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_FETCH;
    endcase
  end

  assign state_change = (state_next != state);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_FETCH;
      trap_cause_q <= CAUSE_NONE;
    end else begin
      state <= state_next;
      if (state != S_TRAP && state_next == S_TRAP) begin
        trap_cause_q <= cause_next;
      end
    end
  end

  // Outputs decode the state; reset gates them so an in-flight write drops at once.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PC_SRC_ALU;
    old_pc_write  = 1'b0;
    alu_op        = ALU_ADD;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    reg_write     = 1'b0;
    wb_sel        = WB_ALU_OUT;
    retire        = 1'b0;
    trap          = 1'b0;
    trap_cause    = CAUSE_NONE;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req      = 1'b1;
          old_pc_write = 1'b1;
          alu_src_a    = SRC_A_PC;
          alu_src_b    = SRC_B_FOUR;
          alu_op       = ALU_ADD;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_SRC_ALU;
          end
        end
        S_DECODE: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_IMM;
          alu_op    = ALU_ADD;
        end
        S_EXEC_R: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_RS2;
          alu_op    = ALU_RTYPE;
        end
        S_EXEC_I: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          alu_op    = ALU_ITYPE;
        end
        S_LUI: begin
          alu_src_a = SRC_A_ZERO;
          alu_src_b = SRC_B_IMM;
        end
        S_AUIPC: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_IMM;
        end
        S_WB_ALU: begin
          reg_write = 1'b1;
          wb_sel    = WB_ALU_OUT;
          retire    = 1'b1;
        end
        S_ADDR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
        end
        S_MEM_RD: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
        end
        S_WB_MEM: begin
          reg_write = 1'b1;
          wb_sel    = WB_MEM;
          retire    = 1'b1;
        end
        S_MEM_WR: begin
          mem_req      = 1'b1;
          mem_we       = 1'b1;
          mem_addr_sel = 1'b1;
          retire       = mem_ready;
        end
        S_BRANCH: begin
          alu_src_a     = SRC_A_RS1;
          alu_src_b     = SRC_B_RS2;
          alu_op        = ALU_BRANCH;
          pc_write_cond = 1'b1;
          pc_src        = PC_SRC_ALU_OUT;
          retire        = 1'b1;
        end
        S_JAL: begin
          reg_write = 1'b1;
          wb_sel    = WB_PC;
          pc_write  = 1'b1;
          pc_src    = PC_SRC_ALU_OUT;
          retire    = 1'b1;
        end
        S_JALR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          reg_write = 1'b1;
          wb_sel    = WB_PC;
          pc_write  = 1'b1;
          pc_src    = PC_SRC_ALU;
          retire    = 1'b1;
        end
        S_TRAP: begin
          trap       = 1'b1;
          trap_cause = trap_cause_q;
        end
        default: begin
          trap = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle control vectors checked
// against hand-written expectations, MEM_TIMEOUT set to 4.
module tb_multicycle_control_fsm;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_write_cond;
  logic       pc_src, old_pc_write, reg_write, retire, trap;
  logic [1:0] alu_op, alu_src_a, alu_src_b, wb_sel, trap_cause;

  int n_cmp;
  int n_fail;

  multicycle_control_fsm #(
    .MEM_TIMEOUT (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr_sel  (mem_addr_sel),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_src        (pc_src),
    .old_pc_write  (old_pc_write),
    .alu_op        (alu_op),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .reg_write     (reg_write),
    .wb_sel        (wb_sel),
    .retire        (retire),
    .trap          (trap),
    .trap_cause    (trap_cause)
  );

  // {req, we, addr_sel, ir_wr, pc_wr, pc_wr_cond, pc_src, old_pc_wr,
  //  alu_op, src_a, src_b, reg_write, wb_sel, retire, trap, trap_cause}
  wire [20:0] obs = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_write_cond,
                     pc_src, old_pc_write, alu_op, alu_src_a, alu_src_b, reg_write,
                     wb_sel, retire, trap, trap_cause};

  localparam logic [20:0] V_ZERO     = 21'd0;
  localparam logic [20:0] V_FETCH_W  = {8'b1000_0001, 2'b00, 2'b00, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
  localparam logic [20:0] V_FETCH_R  = {8'b1001_1001, 2'b00, 2'b00, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
  localparam logic [20:0] V_DECODE   = {8'b0000_0000, 2'b00, 2'b01, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
  localparam logic [20:0] V_EXEC_R   = {8'b0000_0000, 2'b11, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
  localparam logic [20:0] V_EXEC_I   = {8'b0000_0000, 2'b10, 2'b10, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
  localparam logic [20:0] V_LUI      = {8'b0000_0000, 2'b00, 2'b11, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
  localparam logic [20:0] V_AUIPC    = {8'b0000_0000, 2'b00, 2'b01, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
  localparam logic [20:0] V_WB_ALU   = {8'b0000_0000, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00};
  localparam logic [20:0] V_ADDR     = {8'b0000_0000, 2'b00, 2'b10, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
  localparam logic [20:0] V_MEM_RD   = {8'b1010_0000, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
  localparam logic [20:0] V_WB_MEM   = {8'b0000_0000, 2'b00, 2'b00, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 2'b00};
  localparam logic [20:0] V_MEM_WR_W = {8'b1110_0000, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
  localparam logic [20:0] V_MEM_WR_R = {8'b1110_0000, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00};
  localparam logic [20:0] V_BRANCH   = {8'b0000_0110, 2'b01, 2'b10, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00};
  localparam logic [20:0] V_JAL      = {8'b0000_1010, 2'b00, 2'b00, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 2'b00};
  localparam logic [20:0] V_JALR     = {8'b0000_1000, 2'b00, 2'b10, 2'b01, 1'b1, 2'b10, 1'b1, 1'b0, 2'b00};
  localparam logic [20:0] V_TRAP_ILL = {8'b0000_0000, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 2'b01};
  localparam logic [20:0] V_TRAP_TO  = {8'b0000_0000, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10};

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_JL = 7'b1101111;
  localparam logic [6:0] OP_JR = 7'b1100111;
  localparam logic [6:0] OP_LU = 7'b0110111;
  localparam logic [6:0] OP_AU = 7'b0010111;
  localparam logic [6:0] OP_XX = 7'b1111111;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drivers
  task automatic drive(input logic [6:0] op, input logic rdy);
    opcode    = op;
    mem_ready = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    rst = 1'b1;
    drive(OP_R, 1'b1);
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (obs !== V_ZERO) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want %h", obs, V_ZERO);
    end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_alu_types();
    logic [6:0]  ops  [4];
    logic [20:0] exec [4];
    logic [20:0] exp  [4];
    ops  = '{OP_R, OP_I, OP_LU, OP_AU};
    exec = '{V_EXEC_R, V_EXEC_I, V_LUI, V_AUIPC};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      exp = '{V_FETCH_R, V_DECODE, exec[k], V_WB_ALU};
      for (int i = 0; i < 4; i++) begin
        drive(ops[k], 1'b1);
        @(negedge clk);
        n_cmp++;
        if (obs !== exp[i]) begin
          n_fail++;
          $display("FAIL alu_type op=%b cyc%0d: got %h want %h", ops[k], i, obs, exp[i]);
        end
        next_cycle();
      end
    end
  endtask

  task automatic test_load_wait();
    logic [20:0] exp [8];
    logic        rdy [8];
    exp = '{V_FETCH_R, V_DECODE, V_ADDR, V_MEM_RD, V_MEM_RD, V_MEM_RD, V_MEM_RD, V_WB_MEM};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(OP_LD, rdy[i]);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL load_wait cyc%0d: got %h want %h", i, obs, exp[i]);
      end
      next_cycle();
    end
    drive(OP_LD, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (obs !== V_FETCH_W) begin
      n_fail++;
      $display("FAIL load_return_fetch: got %h want %h", obs, V_FETCH_W);
    end
  endtask

  task automatic test_store();
    logic [20:0] exp [5];
    logic        rdy [5];
    exp = '{V_FETCH_R, V_DECODE, V_ADDR, V_MEM_WR_R, V_FETCH_W};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(OP_ST, rdy[i]);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL store cyc%0d: got %h want %h", i, obs, exp[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0]  ops [10];
    logic [20:0] exp [10];
    ops = '{OP_BR, OP_BR, OP_BR, OP_JL, OP_JL, OP_JL, OP_JR, OP_JR, OP_JR, OP_R};
    exp = '{V_FETCH_R, V_DECODE, V_BRANCH, V_FETCH_R, V_DECODE, V_JAL,
            V_FETCH_R, V_DECODE, V_JALR, V_FETCH_W};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(ops[i], (i == 9) ? 1'b0 : 1'b1);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL back_to_back cyc%0d: got %h want %h", i, obs, exp[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_illegal();
    int bad;
    do_reset();
    drive(OP_XX, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (obs !== V_FETCH_R) begin
      n_fail++;
      $display("FAIL illegal_fetch: got %h want %h", obs, V_FETCH_R);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (obs !== V_DECODE) begin
      n_fail++;
      $display("FAIL illegal_decode: got %h want %h", obs, V_DECODE);
    end
    next_cycle();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      drive(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
      @(negedge clk);
      if (obs !== V_TRAP_ILL) bad++;
      if (i == 19) begin
        n_cmp++;
        if (bad != 0) begin
          n_fail++;
          $display("FAIL illegal_trap_hold: %0d of 20 cycles wrong, last got %h want %h",
                   bad, obs, V_TRAP_ILL);
        end
      end
      next_cycle();
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== V_ZERO) begin
      n_fail++;
      $display("FAIL illegal_rst_clear: got %h want %h", obs, V_ZERO);
    end
    next_cycle();
    rst = 1'b0;
    drive(OP_R, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (obs !== V_FETCH_W) begin
      n_fail++;
      $display("FAIL illegal_after_rst: got %h want %h", obs, V_FETCH_W);
    end
    next_cycle();
  endtask

  task automatic test_timeout();
    logic [20:0] exp [6];
    logic        rdy [6];
    // Fetch never answered: four request cycles then trap.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(OP_R, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (obs !== ((i < 4) ? V_FETCH_W : V_TRAP_TO)) begin
        n_fail++;
        $display("FAIL timeout_fetch cyc%0d: got %h want %h", i, obs,
                 (i < 4) ? V_FETCH_W : V_TRAP_TO);
      end
      next_cycle();
    end
    // Ready on the fourth request cycle wins.
    exp = '{V_FETCH_W, V_FETCH_W, V_FETCH_W, V_FETCH_R, V_DECODE, V_EXEC_R};
    rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(OP_R, rdy[i]);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL timeout_edge cyc%0d: got %h want %h", i, obs, exp[i]);
      end
      next_cycle();
    end
    // Load data phase never answered.
    exp = '{V_MEM_RD, V_MEM_RD, V_MEM_RD, V_MEM_RD, V_TRAP_TO, V_TRAP_TO};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(OP_LD, 1'b1);
      next_cycle();
    end
    for (int i = 0; i < 6; i++) begin
      drive(OP_LD, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL timeout_memrd cyc%0d: got %h want %h", i, obs, exp[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(OP_ST, 1'b1);
      next_cycle();
    end
    drive(OP_ST, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (obs !== V_MEM_WR_W) begin
      n_fail++;
      $display("FAIL midwr_before_rst: got %h want %h", obs, V_MEM_WR_W);
    end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({mem_req, mem_we} !== 2'b00 || obs !== V_ZERO) begin
      n_fail++;
      $display("FAIL midwr_async_drop: got %h want %h", obs, V_ZERO);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== V_FETCH_W) begin
      n_fail++;
      $display("FAIL midwr_after_rst: got %h want %h", obs, V_FETCH_W);
    end
  endtask

  // Sequence and report
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    drive(OP_R, 1'b0);
    test_reset();
    test_alu_types();
    test_load_wait();
    test_store();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
